// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared mem opcodes, stall-bus constants and opcode helpers
package mem_access_unit_pkg;
  localparam int ALU_OP_W = 8;
  localparam int STALL_W = 6;
  localparam int STALL_MEMWB = 4;
  localparam logic [4:0] NOP_REG_ADDR = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'd0;
  localparam logic [ALU_OP_W-1:0] MEM_NOP = 8'h00;
  localparam logic [ALU_OP_W-1:0] MEM_LB = 8'hE0;
  localparam logic [ALU_OP_W-1:0] MEM_LH = 8'hE1;
  localparam logic [ALU_OP_W-1:0] MEM_LW = 8'hE3;
  localparam logic [ALU_OP_W-1:0] MEM_LBU = 8'hE4;
  localparam logic [ALU_OP_W-1:0] MEM_LHU = 8'hE5;
  localparam logic [ALU_OP_W-1:0] MEM_SB = 8'hE8;
  localparam logic [ALU_OP_W-1:0] MEM_SH = 8'hE9;
  localparam logic [ALU_OP_W-1:0] MEM_SW = 8'hEB;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} mau_state_e;
  function automatic logic [2:0] byte_cnt(input logic [ALU_OP_W-1:0] op);
    return (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 3'd1 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 3'd2 :
           (op == MEM_LW || op == MEM_SW) ? 3'd4 : 3'd0;
  endfunction
  function automatic logic is_load(input logic [ALU_OP_W-1:0] op);
    return op == MEM_LB || op == MEM_LH || op == MEM_LW || op == MEM_LBU || op == MEM_LHU;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: sign/zero-extends an assembled little-endian load value by opcode
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0]         raw,
  input  logic [ALU_OP_W-1:0] op,
  output logic [31:0]         res
);
  always_comb
    res = op == MEM_LB  ? {{24{raw[7]}}, raw[7:0]} :
          op == MEM_LBU ? {24'd0, raw[7:0]} :
          op == MEM_LH  ? {{16{raw[15]}}, raw[15:0]} :
          op == MEM_LHU ? {16'd0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage engine moving loads/stores as byte transfers; non-memory ops pass straight through
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OP_W = ALU_OP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         mem_wd,
  input  logic               mem_wreg,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic [ADDR_W-1:0]  mem_mem_addr,
  input  logic [OP_W-1:0]    mem_aluop,
  input  logic [STALL_W-1:0] stall_state,
  output logic               stall_req,
  output logic [4:0]         wb_wd,
  output logic               wb_wreg,
  output logic [DATA_W-1:0]  wb_wdata,
  output logic               mc_req,
  output logic               mc_we,
  output logic [ADDR_W-1:0]  mc_addr,
  output logic [7:0]         mc_wdata,
  input  logic               mc_ready,
  input  logic [7:0]         mc_rdata
);
  mau_state_e state_q, state_d;
  logic [2:0] issue_cnt_q, issue_cnt_d, recv_cnt_q, recv_cnt_d, n;
  logic [31:0] asm_q, asm_d, ext;
  logic ld, mem_op, acc, last, pend, clr, pass, ldone, unused;
  assign unused = ^{stall_state[STALL_W-1:STALL_MEMWB+1], stall_state[STALL_MEMWB-1:0]};
  assign n = byte_cnt(mem_aluop);
  assign mem_op = n != 3'd0;
  assign ld = is_load(mem_aluop);
  // issue_cnt is zero in IDLE, so it doubles as the byte index in every state
  assign mc_req = !rst && ((state_q == S_IDLE && mem_op) || state_q == S_ACCESS);
  assign mc_we = mc_req && !ld;
  assign mc_addr = mc_req ? mem_mem_addr + ADDR_W'(issue_cnt_q) : '0;
  assign mc_wdata = mc_we ? 8'(mem_wdata >> {issue_cnt_q, 3'b000}) : 8'd0;
  assign acc = mc_req && mc_ready;
  assign last = issue_cnt_q == n - 3'd1;
  // read data lags its accept by one cycle, so a byte is pending whenever recv trails issue
  assign pend = ld && recv_cnt_q != issue_cnt_q;
  assign clr = state_q == S_DONE && !stall_state[STALL_MEMWB];
  assign stall_req = state_q == S_IDLE ? mem_op : state_q != S_DONE;
  assign pass = state_q == S_IDLE && !mem_op;
  assign ldone = state_q == S_DONE && ld;
  assign wb_wd = (pass || ldone) ? mem_wd : NOP_REG_ADDR;
  assign wb_wreg = (pass || ldone) && mem_wreg;
  assign wb_wdata = pass ? mem_wdata : ldone ? DATA_W'(ext) : DATA_W'(ZERO_WORD);
  load_extend u_ext (.raw(asm_q), .op(ALU_OP_W'(mem_aluop)), .res(ext));
  always_comb begin
    state_d = acc ? (last ? (ld ? S_WAIT : S_DONE) : S_ACCESS) :
              state_q == S_WAIT ? S_DONE : clr ? S_IDLE : state_q;
    issue_cnt_d = clr ? 3'd0 : issue_cnt_q + 3'(acc);
    recv_cnt_d = clr ? 3'd0 : recv_cnt_q + 3'(pend);
    asm_d = clr ? 32'd0 : pend ? asm_q | (32'(mc_rdata) << {recv_cnt_q, 3'b000}) : asm_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      issue_cnt_q <= 3'd0;
      recv_cnt_q <= 3'd0;
      asm_q <= 32'd0;
    end else begin
      state_q <= state_d;
      issue_cnt_q <= issue_cnt_d;
      recv_cnt_q <= recv_cnt_d;
      asm_q <= asm_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized load/store traffic against a byte-memory and transaction-level model
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;
  logic clk = 0, rst = 1;
  logic [4:0] mem_wd, wb_wd;
  logic mem_wreg, wb_wreg, stall_req, mc_req, mc_we, mc_ready;
  logic [31:0] mem_wdata, mem_mem_addr, wb_wdata, mc_addr;
  logic [7:0] mem_aluop, mc_wdata, mc_rdata;
  logic [5:0] stall_state;
  int checks = 0, errors = 0;
  logic [7:0] mem [logic [31:0]];
  logic [7:0] ops [11];
  logic [7:0] op_r;
  logic [31:0] a_r;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .rst(rst), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_mem_addr(mem_mem_addr), .mem_aluop(mem_aluop), .stall_state(stall_state),
    .stall_req(stall_req), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .mc_req(mc_req), .mc_we(mc_we), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_ready(mc_ready), .mc_rdata(mc_rdata)
  );
  function automatic logic [7:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction
  function automatic int nbytes(input logic [7:0] op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      MEM_LW, MEM_SW: return 4;
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wd, input logic wreg, input int pct, input int stall_k,
                        input int stall_len, input int hold, input logic [31:0] lit,
                        input bit lit_en, input int lit_stall);
    int n, k, cyc, hold_left, stall_left, lat;
    bit ld, all_rdy, done, fin, acc_s, we_s;
    logic [31:0] want, a_s;
    logic [7:0] d_s;
    n = nbytes(op);
    ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    k = 0; cyc = 0; lat = 0; hold_left = hold; stall_left = stall_len;
    all_rdy = 1; done = 0; fin = 0;
    want = 0;
    for (int i = 0; i < n; i++) want |= 32'(rd(addr + 32'(i))) << (8 * i);
    if (op == MEM_LB) want = (want ^ 32'h80) - 32'h80;
    if (op == MEM_LH) want = (want ^ 32'h8000) - 32'h8000;
    if (!ld) want = 0;
    mem_aluop = op; mem_mem_addr = addr; mem_wdata = wdata; mem_wd = wd; mem_wreg = wreg;
    stall_state = 6'($urandom) & 6'h2f;
    while (!fin) begin
      if (k == stall_k && stall_left > 0) begin
        mc_ready = 0;
        stall_left--;
      end else mc_ready = $urandom_range(1, 100) <= pct;
      @(negedge clk);
      cyc++;
      if (!mc_req) begin
        chk("bus_idle_addr", mc_addr, 0);
        chk("bus_idle_we_wdata", {mc_we, mc_wdata}, 0);
      end
      if (n == 0) begin
        chk("pt_stall_req", {stall_req, mc_req}, 0);
        chk("pt_wdata", wb_wdata, wdata);
        chk("pt_wd_wreg", {wb_wreg, wb_wd}, {wreg, wd});
        fin = 1;
      end else if (!done && stall_req) begin
        lat++;
        if (mc_req) begin
          chk("req_addr", mc_addr, addr + 32'(k));
          chk("req_we", mc_we, !ld);
          if (!ld) chk("req_wdata", mc_wdata, 8'(wdata >> (8 * k)));
          if (!mc_ready) all_rdy = 0;
        end
      end else begin
        if (!done) begin
          done = 1;
          chk("byte_count", k, n);
          if (all_rdy) chk("latency", lat, ld ? n + 1 : n);
          if (lit_stall >= 0) chk("latency_lit", lat, lit_stall);
          if (lit_en) chk("result_lit", wb_wdata, lit);
        end
        chk("done_stall_req", {stall_req, mc_req}, 0);
        chk("done_wdata", wb_wdata, want);
        chk("done_wd_wreg", {wb_wreg, wb_wd}, ld ? {wreg, wd} : 6'd0);
        stall_state[4] = hold_left > 0;
        if (hold_left == 0) fin = 1;
        else hold_left--;
      end
      if (cyc > 400 && !fin) begin
        checks++; errors++;
        $display("FAIL timeout op=%h cycles=%0d limit=400", op, cyc);
        fin = 1;
      end
      acc_s = mc_req && mc_ready; we_s = mc_we; a_s = mc_addr; d_s = mc_wdata;
      @(posedge clk); #1;
      if (acc_s) begin
        k++;
        if (we_s) mem[a_s] = d_s;
      end
      mc_rdata = (acc_s && !we_s) ? rd(a_s) : 8'($urandom);
    end
    stall_state[4] = 0;
  endtask
  initial begin
    ops = '{MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW, 8'h21, 8'h2f};
    mem[32'h40] = 8'h80;
    mem[32'h103] = 8'h11; mem[32'h104] = 8'h22; mem[32'h105] = 8'h33; mem[32'h106] = 8'h44;
    mem[32'h200] = 8'h01; mem[32'h201] = 8'h80;
    mem_aluop = MEM_NOP; mem_mem_addr = 0; mem_wdata = 0; mem_wd = 0; mem_wreg = 0;
    stall_state = 0; mc_ready = 0; mc_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_idle", {stall_req, mc_req, wb_wreg}, 0);
    mem_aluop = MEM_LW; mem_mem_addr = 32'h40; mc_ready = 1;
    @(negedge clk);
    chk("rst_memop_mc_req", mc_req, 0);
    chk("rst_memop_stall_req", stall_req, 1);
    chk("rst_memop_addr", mc_addr, 0);
    @(posedge clk); #1;
    rst = 0;
    run_op(8'h21, 32'h0, 32'h12345678, 5'd5, 1, 100, -1, 0, 0, 0, 0, -1);
    run_op(MEM_LB, 32'h40, 32'h0, 5'd3, 1, 100, -1, 0, 0, 32'hFFFFFF80, 1, 2);
    run_op(MEM_LBU, 32'h40, 32'h0, 5'd4, 1, 100, -1, 0, 0, 32'h00000080, 1, 2);
    run_op(MEM_LW, 32'h103, 32'h0, 5'd6, 1, 100, -1, 0, 0, 32'h44332211, 1, 5);
    mem_aluop = MEM_LW; mem_mem_addr = 32'h103; mem_wd = 7; mem_wreg = 1; mc_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midop_rst_mc_req", mc_req, 0);
    chk("midop_rst_stall_req", stall_req, 1);
    @(posedge clk); #1;
    rst = 0;
    run_op(MEM_LW, 32'h103, 32'h0, 5'd7, 1, 100, -1, 0, 0, 32'h44332211, 1, 5);
    run_op(MEM_SW, 32'h100, 32'hDEADBEEF, 5'd8, 1, 100, 2, 2, 0, 0, 0, -1);
    chk("sw_mem_bytes", {rd(32'h103), rd(32'h102), rd(32'h101), rd(32'h100)}, 32'hDEADBEEF);
    run_op(MEM_LHU, 32'h200, 32'h0, 5'd9, 1, 100, -1, 0, 3, 32'h00008001, 1, 3);
    run_op(MEM_SW, 32'hFFFFFFFE, 32'hA1B2C3D4, 5'd1, 1, 100, -1, 0, 0, 0, 0, 4);
    run_op(MEM_LW, 32'hFFFFFFFE, 32'h0, 5'd2, 1, 100, -1, 0, 0, 32'hA1B2C3D4, 1, 5);
    for (int t = 0; t < 80; t++) begin
      op_r = ops[$urandom_range(0, 10)];
      a_r = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                        : 32'h1000 + 32'($urandom_range(0, 31));
      run_op(op_r, a_r, $urandom, 5'($urandom), 1'($urandom), $urandom_range(30, 100),
             $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2), 0, 0, -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine. Consumes the op held in the EX/MEM pipeline register: destination, write-enable, data, memory address and mem opcode.
- Executes loads and stores as a sequence of byte transfers on the 8-bit memory-controller port.
- Raises a stall request while the access is in flight, and drives the MEM/WB-bound result.
- Non-memory ops pass straight through with zero added latency.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, register/result width.
- OP_W, 8, mem-opcode width; matches the shared AluOp bus.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  write-enable from EX/MEM
- mem_wdata  in  DATA_W  ALU result for non-memory ops; store data for stores
- mem_mem_addr  in  ADDR_W  effective byte address
- mem_aluop  in  OP_W  MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW
- stall_state  in  6  global stall vector; bit4 set means the MEM/WB register is held
- stall_req  out  1  request stall of stages 0..3
- wb_wd  out  5  destination register to MEM/WB
- wb_wreg  out  1  write-enable to MEM/WB
- wb_wdata  out  DATA_W  result to MEM/WB
- mc_req  out  1  byte-transfer request
- mc_we  out  1  1 = write byte, 0 = read byte
- mc_addr  out  ADDR_W  byte address
- mc_wdata  out  8  write byte
- mc_ready  in  1  controller accepts the current request this cycle
- mc_rdata  in  8  read byte; valid the cycle after the accepting cycle

Behaviour:
- Transfer rule: one byte moves when mc_req && mc_ready at the clock edge.
- Byte count n: 1 for B/BU, 2 for H/HU, 4 for W. Byte i goes to address mem_mem_addr+i (wraps mod 2^ADDR_W), little-endian. Misaligned addresses are legal and need no special case.
- Store byte i = mem_wdata[8i+7:8i].
- States:
  - IDLE:
    - Non-memory op: stall_req=0, mc_req=0; wb_* = mem_wd/mem_wreg/mem_wdata combinationally.
    - Memory op: stall_req=1, mc_req=1, byte 0 issued combinationally.
    - On accept: issue_cnt=1, then go to ACCESS if n>1, WAIT if load with n==1, DONE if store with n==1.
  - ACCESS:
    - mc_req=1 with byte issue_cnt; issue_cnt increments on accept.
    - A load captures mc_rdata into assembly byte recv_cnt in every cycle that follows an accept.
    - When the last byte is accepted: go to WAIT (load) or DONE (store).
  - WAIT (loads only): mc_req=0, capture the final byte, then go to DONE.
  - DONE:
    - stall_req=0, mc_req=0.
    - Load: wb_wdata = assembled value. LB/LH sign-extend; LBU/LHU zero-extend. wb_wreg=mem_wreg, wb_wd=mem_wd.
    - Store: wb_wreg=0, wb_wd=0, wb_wdata=0.
    - Stay in DONE while stall_state[4]=1; return to IDLE when stall_state[4]=0, since the pipeline advances that edge.
- Invariant: an op is never re-issued. The EX/MEM register holds the same op during the stall, and the engine leaves DONE only on the advancing edge.
- Latency with mc_ready held high: stall_req high for n+1 cycles (load) or n cycles (store); result valid in the DONE cycle.
- Backpressure: mc_ready=0 holds mc_req, mc_addr and mc_wdata stable; counters do not move.
- mc_we, mc_addr and mc_wdata are 0 whenever mc_req=0.
- Reset (including mid-operation): state IDLE, counters 0, assembly register 0, mc_req 0. The held op then restarts from byte 0, so a partial store may be rewritten; this is acceptable.
- MEM_NOP or an unknown opcode is treated as non-memory pass-through.

Decomposition:
- Shared defines: opcodes MEM_NOP/LB/LH/LW/LBU/LHU/SB/SH/SW, OP_W, StallBus width, the stall bit index constants, NOPRegAddr, ZeroWord.
- Sub-module load_extend (combinational): takes the 32-bit assembled value plus opcode and returns the sign/zero-extended result.
- FSM and counters stay in the top module.

Test Plan:
- ADD-type op, mem_wdata=0x12345678, wd=5, wreg=1 -> same cycle wb_wdata=0x12345678, wb_wd=5, stall_req=0, mc_req=0.
- LB at 0x40, memory byte 0x80, mc_ready=1 -> stall_req high 2 cycles, DONE cycle wb_wdata=0xFFFFFF80; LBU on the same byte -> 0x00000080.
- LW at 0x103, bytes 0x11,0x22,0x33,0x44 -> mc_addr sequence 0x103..0x106, stall_req high 5 cycles, wb_wdata=0x44332211.
- SW 0xDEADBEEF at 0x100 with mc_ready low for 2 cycles on byte 2 -> writes EF,BE,AD,DE to 0x100..0x103; addr/wdata stable while stalled; wb_wreg=0.
- LHU at 0x200, bytes 0x01,0x80, stall_state[4] held 3 extra cycles in DONE -> no new mc_req, wb_wdata stays 0x00008001 until release, then IDLE.
- rst asserted after the second byte of an LW -> next cycle mc_req=0, stall_req reflects a fresh restart, and the op reissues from byte 0 after reset deasserts.
